prime_table_gen: RTL and testbench



---
 rtl/prime_table_gen_if.sv | 29 ++
 rtl/prime_table_gen.sv | 162 ++++++++++++++++
 tb/tb_prime_table_gen.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prime_table_gen_if.sv
// Control handshake and single-port memory bus for the prime table generator.
// The generator uses modport master; the controller/memory side uses slave.
interface prime_table_gen_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 9
);
    logic              start;
    logic [DATA_W-1:0] bound;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W-1:0] prime_count;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        input  start, bound, mem_dout,
        output busy, done, overflow, prime_count,
        output mem_we, mem_addr, mem_din
    );

    modport slave (
        output start, bound, mem_dout,
        input  busy, done, overflow, prime_count,
        input  mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/prime_table_gen.sv
// Fills a prime table with ascending primes <= bound by trial division
// against primes already stored, using the memory's single port.
module prime_table_gen #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 9,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_PRIMES = 128,
    parameter int RD_LAT     = 1
) (
    input logic clk,
    input logic rst,
    prime_table_gen_if.master bus
);
    localparam int CW    = DATA_W + 1;
    localparam int LAT_W = 4;

    typedef enum logic [2:0] {
        IDLE, WR2, NEXT, RD, CHK, MOD, WRP, DONE
    } state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] bound_q, bound_n;
    logic [CW-1:0]     cand, cand_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W-1:0] count, count_n;
    logic [CW-1:0]     rem, rem_n;
    logic [DATA_W-1:0] p, p_n;
    logic              ovf, ovf_n;
    logic [LAT_W-1:0]  lat, lat_n;

    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;

    logic [2*DATA_W-1:0] sq;
    logic [2*DATA_W-1:0] cand_ext;

    // Square is taken at full width so 511*511 cannot wrap.
    assign sq = {{DATA_W{1'b0}}, bus.mem_dout}
              * {{DATA_W{1'b0}}, bus.mem_dout};
    assign cand_ext = {{(DATA_W-1){1'b0}}, cand};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bound_q <= '0;
            cand    <= '0;
            idx     <= '0;
            count   <= '0;
            rem     <= '0;
            p       <= '0;
            ovf     <= 1'b0;
            lat     <= '0;
        end else begin
            state   <= state_n;
            bound_q <= bound_n;
            cand    <= cand_n;
            idx     <= idx_n;
            count   <= count_n;
            rem     <= rem_n;
            p       <= p_n;
            ovf     <= ovf_n;
            lat     <= lat_n;
        end
    end

    always_comb begin
        state_n = state;
        bound_n = bound_q;
        cand_n  = cand;
        idx_n   = idx;
        count_n = count;
        rem_n   = rem;
        p_n     = p;
        ovf_n   = ovf;
        lat_n   = lat;
        we      = 1'b0;
        addr    = ADDR_W'(BASE_ADDR);
        din     = '0;
        unique case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    bound_n = bus.bound;
                    count_n = '0;
                    ovf_n   = 1'b0;
                    state_n = (bus.bound < DATA_W'(2)) ? DONE : WR2;
                end
            end
            WR2: begin
                we      = 1'b1;
                din     = DATA_W'(2);
                count_n = ADDR_W'(1);
                cand_n  = CW'(3);
                state_n = NEXT;
            end
            NEXT: begin
                if (cand > {1'b0, bound_q}) begin
                    state_n = DONE;
                end else if (count == ADDR_W'(MAX_PRIMES)) begin
                    ovf_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    // Candidates are odd, so division by 2 is skipped.
                    idx_n   = ADDR_W'(1);
                    lat_n   = '0;
                    state_n = RD;
                end
            end
            RD: begin
                if (idx == count) begin
                    state_n = WRP;
                end else begin
                    addr = ADDR_W'(BASE_ADDR) + idx;
                    if (lat == LAT_W'(RD_LAT - 1)) begin
                        lat_n   = '0;
                        state_n = CHK;
                    end else begin
                        lat_n = lat + LAT_W'(1);
                    end
                end
            end
            CHK: begin
                p_n = bus.mem_dout;
                if (sq > cand_ext) begin
                    state_n = WRP;
                end else begin
                    rem_n   = cand;
                    state_n = MOD;
                end
            end
            MOD: begin
                if (rem >= {1'b0, p}) begin
                    rem_n = rem - {1'b0, p};
                end else if (rem == '0) begin
                    cand_n  = cand + CW'(2);
                    state_n = NEXT;
                end else begin
                    idx_n   = idx + ADDR_W'(1);
                    lat_n   = '0;
                    state_n = RD;
                end
            end
            WRP: begin
                we      = 1'b1;
                addr    = ADDR_W'(BASE_ADDR) + count;
                din     = cand[DATA_W-1:0];
                count_n = count + ADDR_W'(1);
                cand_n  = cand + CW'(2);
                state_n = NEXT;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.busy        = (state != IDLE) && (state != DONE);
    assign bus.done        = (state == DONE);
    assign bus.overflow    = ovf;
    assign bus.prime_count = count;
    assign bus.mem_we      = we;
    assign bus.mem_addr    = addr;
    assign bus.mem_din     = din;
endmodule

// File: tb/tb_prime_table_gen.sv
// Bench for prime_table_gen: table vectors, corner sequences and random
// bounds checked against a sieve-based model of the prime table.
module tb_prime_table_gen;
    localparam int AW     = 13;
    localparam int DW     = 9;
    localparam int BUDGET = 60000;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int which;
        int b;
        int exp_cnt;
        int exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prime_table_gen_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    prime_table_gen_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

    prime_table_gen #(
        .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0),
        .MAX_PRIMES(128), .RD_LAT(1)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    prime_table_gen #(
        .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0),
        .MAX_PRIMES(4), .RD_LAT(1)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    logic [DW-1:0] mem_a [0:(1<<AW)-1];
    logic [DW-1:0] mem_b [0:(1<<AW)-1];
    wr_t log_a[$];
    wr_t log_b[$];

    // Single-port memories with one cycle read latency.
    always @(posedge clk) begin
        if (ifa.mem_we) begin
            mem_a[ifa.mem_addr] <= ifa.mem_din;
            log_a.push_back({ifa.mem_addr, ifa.mem_din});
        end
        ifa.mem_dout <= mem_a[ifa.mem_addr];
        if (ifb.mem_we) begin
            mem_b[ifb.mem_addr] <= ifb.mem_din;
            log_b.push_back({ifb.mem_addr, ifb.mem_din});
        end
        ifb.mem_dout <= mem_b[ifb.mem_addr];
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: sieve of Eratosthenes, truncated to the table capacity.
    function automatic void model(input int b, input int maxp,
                                  output int lst[$], output bit ovf);
        bit comp [0:1023];
        int nxt;
        for (int i = 0; i < 1024; i++) comp[i] = 1'b0;
        lst = {};
        ovf = 1'b0;
        for (int n = 2; n <= b; n++) begin
            if (!comp[n]) begin
                if (lst.size() < maxp) lst.push_back(n);
                for (int m = n * n; m <= b; m += n) comp[m] = 1'b1;
            end
        end
        if (lst.size() == maxp) begin
            nxt = (maxp == 1) ? 3 : lst[maxp-1] + 2;
            ovf = (nxt <= b);
        end
    endfunction

    task automatic clear(input int which);
        for (int i = 0; i < 256; i++) begin
            if (which == 0) mem_a[i] = '0;
            else mem_b[i] = '0;
        end
        if (which == 0) log_a = {};
        else log_b = {};
    endtask

    task automatic pulse_start(input int which, input int b);
        @(posedge clk); #1;
        if (which == 0) begin
            ifa.start = 1'b1;
            ifa.bound = DW'(b);
        end else begin
            ifb.start = 1'b1;
            ifb.bound = DW'(b);
        end
        @(posedge clk); #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input string tag);
        int cyc = 0;
        while (((which == 0) ? ifa.done : ifb.done) !== 1'b1
               && cyc < BUDGET) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= BUDGET) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
        end
    endtask

    task automatic verify(input int which, input int b, input int maxp,
                          input string tag, output int cnt, output int ovf);
        int  lst[$];
        bit  eovf;
        wr_t lg[$];
        int  errs;
        int  nn;
        model(b, maxp, lst, eovf);
        if (which == 0) begin
            lg  = log_a;
            cnt = int'(ifa.prime_count);
            ovf = int'(ifa.overflow);
            check($sformatf("%s busy", tag), int'(ifa.busy), 0);
        end else begin
            lg  = log_b;
            cnt = int'(ifb.prime_count);
            ovf = int'(ifb.overflow);
            check($sformatf("%s busy", tag), int'(ifb.busy), 0);
        end
        check($sformatf("%s model_count", tag), cnt, lst.size());
        check($sformatf("%s model_ovf", tag), ovf, int'(eovf));
        check($sformatf("%s writes", tag), lg.size(), lst.size());
        errs = 0;
        nn = (lg.size() < lst.size()) ? lg.size() : lst.size();
        for (int i = 0; i < nn; i++)
            if (int'(lg[i].a) != i || int'(lg[i].d) != lst[i]) errs++;
        check($sformatf("%s write_seq_errs", tag), errs, 0);
        errs = 0;
        for (int i = 0; i < lst.size(); i++) begin
            if (which == 0 && int'(mem_a[i]) != lst[i]) errs++;
            if (which == 1 && int'(mem_b[i]) != lst[i]) errs++;
        end
        check($sformatf("%s readback_errs", tag), errs, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int cnt;
        int ovf;
        int b;
        int n;
        int lst[$];
        bit eovf;

        ifa.start = 1'b0;
        ifa.bound = '0;
        ifb.start = 1'b0;
        ifb.bound = '0;

        vecs = '{
            '{0, 10, 4, 0},  '{0, 2, 1, 0},   '{0, 1, 0, 0},
            '{0, 0, 0, 0},   '{0, 511, 97, 0}, '{1, 100, 4, 1},
            '{1, 7, 4, 0},   '{1, 9, 4, 1},   '{1, 3, 2, 0},
            '{0, 30, 10, 0}
        };

        repeat (3) @(posedge clk);
        #1;
        check("rst busy", int'(ifa.busy), 0);
        check("rst done", int'(ifa.done), 0);
        check("rst overflow", int'(ifa.overflow), 0);
        check("rst count", int'(ifa.prime_count), 0);
        check("rst we", int'(ifa.mem_we), 0);
        check("rst addr", int'(ifa.mem_addr), 0);
        check("rst din", int'(ifa.mem_din), 0);
        check("rst b busy", int'(ifb.busy), 0);
        rst = 1'b0;

        foreach (vecs[k]) begin
            string tag;
            tag = $sformatf("vec%0d b=%0d", k, vecs[k].b);
            clear(vecs[k].which);
            pulse_start(vecs[k].which, vecs[k].b);
            if (vecs[k].b < 2) begin
                check({tag, " done_fast"}, int'(ifa.done), 1);
            end else begin
                check({tag, " busy_after_start"},
                      int'(vecs[k].which == 0 ? ifa.busy : ifb.busy), 1);
                wait_done(vecs[k].which, tag);
            end
            verify(vecs[k].which, vecs[k].b,
                   vecs[k].which == 0 ? 128 : 4, tag, cnt, ovf);
            check({tag, " count"}, cnt, vecs[k].exp_cnt);
            check({tag, " ovf"}, ovf, vecs[k].exp_ovf);
        end

        // Reset in the middle of a run.
        clear(0);
        pulse_start(0, 200);
        repeat (300) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", int'(ifa.busy), 0);
        check("midrst we", int'(ifa.mem_we), 0);
        check("midrst count", int'(ifa.prime_count), 0);
        check("midrst done", int'(ifa.done), 0);
        rst = 1'b0;
        n = log_a.size();
        check("midrst some_written", int'(n > 0), 1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst no_more_writes", log_a.size(), n);
        model(200, 128, lst, eovf);
        cnt = 0;
        for (int i = 0; i < n && i < lst.size(); i++)
            if (int'(mem_a[i]) != lst[i]) cnt++;
        check("midrst kept_prefix_errs", cnt, 0);
        clear(0);
        pulse_start(0, 30);
        wait_done(0, "after_rst b=30");
        verify(0, 30, 128, "after_rst b=30", cnt, ovf);
        check("after_rst count", cnt, 10);

        // Second start while busy must be ignored, bound stays latched.
        clear(0);
        pulse_start(0, 50);
        repeat (20) @(posedge clk);
        pulse_start(0, 5);
        wait_done(0, "restart b=50");
        verify(0, 50, 128, "restart b=50", cnt, ovf);
        check("restart count", cnt, 15);

        // Random bounds against the model.
        for (int r = 0; r < 6; r++) begin
            string tag;
            b = $urandom_range(0, 130);
            tag = $sformatf("rand%0d b=%0d", r, b);
            clear(0);
            pulse_start(0, b);
            wait_done(0, tag);
            verify(0, b, 128, tag, cnt, ovf);
        end

        // Random bounds on the small-capacity instance.
        for (int r = 0; r < 4; r++) begin
            string tag;
            b = $urandom_range(0, 40);
            tag = $sformatf("randb%0d b=%0d", r, b);
            clear(1);
            pulse_start(1, b);
            wait_done(1, tag);
            verify(1, b, 4, tag, cnt, ovf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
